// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, event layout and decoder states.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_SKIP
  } dec_state_e;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
  endfunction

  // Pause is the only source of an extended make carrying code E1.
  function automatic logic is_pause(input ps2_event_t ev);
    return ev.ext && !ev.brk && (ev.code == PS2_PAUSE);
  endfunction

  function automatic logic [31:0] legacy_key(input ps2_event_t ev);
    logic [31:0] k;
    if (is_pause(ev)) begin
      k = {24'h0, PS2_PAUSE};
    end else begin
      case ({ev.ext, ev.brk})
        2'b00:   k = {24'h0, ev.code};
        2'b10:   k = {16'h0, PS2_EXT, ev.code};
        2'b01:   k = {16'h0, PS2_BRK, ev.code};
        default: k = {8'h0, PS2_EXT, PS2_BRK, ev.code};
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/ps2_key_event_queue_sync_fifo.sv
// First-word fall-through FIFO; read data reads as zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr, do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign do_rd = rd_en && !empty;
  // A write into a full FIFO is still taken when the head leaves this cycle.
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Storage array, no reset needed: contents are only visible via count.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-byte decoder with typematic suppression feeding an event FIFO.
module ps2_key_event_queue
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH           = 8,
  parameter bit          SUPPRESS_REPEAT = 1'b1
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       en,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       ev_valid,
  output logic [9:0]                 ev_data,
  input  logic                       ev_ready,
  output logic [$clog2(DEPTH+1)-1:0] ev_count,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic [7:0]                 err_cnt,
  output logic [31:0]                cur_key
);

  dec_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       emit, dec_err, redo;
  ps2_event_t ev;

  logic       held_v_q, held_v_d;
  logic [8:0] held_key_q, held_key_d;
  logic       drop, wr, accept, ovf_set;

  logic        overflow_q;
  logic [7:0]  err_cnt_q;
  logic [31:0] cur_key_q;

  logic       fifo_full, fifo_empty;
  ps2_event_t head;

  // Decoder next state; an illegal prefix is counted then replayed as if seen in IDLE.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    dec_err = 1'b0;
    redo    = 1'b0;
    ev      = '0;
    if (!en) begin
      state_d = ST_IDLE;
      skip_d  = '0;
    end else if (byte_valid) begin
      case (state_q)
        ST_IDLE: redo = 1'b1;
        ST_E0: begin
          if (byte_data == PS2_BRK) begin
            state_d = ST_E0F0;
          end else if (is_prefix(byte_data)) begin
            dec_err = 1'b1;
            redo    = 1'b1;
          end else begin
            emit    = 1'b1;
            ev      = '{ext: 1'b1, brk: 1'b0, code: byte_data};
            state_d = ST_IDLE;
          end
        end
        ST_F0, ST_E0F0: begin
          if (is_prefix(byte_data)) begin
            dec_err = 1'b1;
            redo    = 1'b1;
          end else begin
            emit    = 1'b1;
            ev      = '{ext: (state_q == ST_E0F0), brk: 1'b1, code: byte_data};
            state_d = ST_IDLE;
          end
        end
        default: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = ST_IDLE;
        end
      endcase
      if (redo) begin
        case (byte_data)
          PS2_EXT: state_d = ST_E0;
          PS2_BRK: state_d = ST_F0;
          PS2_PAUSE: begin
            emit    = 1'b1;
            ev      = '{ext: 1'b1, brk: 1'b0, code: PS2_PAUSE};
            skip_d  = PAUSE_SKIP;
            state_d = ST_SKIP;
          end
          default: begin
            emit    = 1'b1;
            ev      = '{ext: 1'b0, brk: 1'b0, code: byte_data};
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Typematic filter and held-key tracking.
  always_comb begin
    held_v_d   = held_v_q;
    held_key_d = held_key_q;
    drop = SUPPRESS_REPEAT && emit && !ev.brk && !is_pause(ev) &&
           held_v_q && (held_key_q == {ev.ext, ev.code});
    wr   = emit && !drop;
    if (SUPPRESS_REPEAT && wr && !is_pause(ev)) begin
      if (!ev.brk) begin
        held_v_d   = 1'b1;
        held_key_d = {ev.ext, ev.code};
      end else if (held_key_q == {ev.ext, ev.code}) begin
        held_v_d = 1'b0;
      end
    end
    accept  = wr && (!fifo_full || ev_ready);
    ovf_set = wr && fifo_full && !ev_ready;
  end

  // Decoder, filter and status registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      held_v_q   <= 1'b0;
      held_key_q <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
      cur_key_q  <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      held_v_q   <= held_v_d;
      held_key_q <= held_key_d;
      overflow_q <= ovf_set || (overflow_q && !clr_ovf);
      if (dec_err && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      if (accept) cur_key_q <= legacy_key(ev);
    end
  end

  sync_fifo #(
    .WIDTH ($bits(ps2_event_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .wr_en   (wr),
    .wr_data (ev),
    .rd_en   (ev_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (ev_count)
  );

  assign ev_valid = !fifo_empty;
  assign ev_data  = head;
  assign overflow = overflow_q;
  assign err_cnt  = err_cnt_q;
  assign cur_key  = cur_key_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
module tb_ps2_key_event_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic clrn, en, byte_valid, ev_ready, clr_ovf;
  logic [7:0] byte_data;

  logic          ev_valid0, ev_valid1, overflow0, overflow1;
  logic [9:0]    ev_data0, ev_data1;
  logic [CW-1:0] ev_count0, ev_count1;
  logic [7:0]    err_cnt0, err_cnt1;
  logic [31:0]   cur_key0, cur_key1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ps2_key_event_queue #(.DEPTH(DEPTH), .SUPPRESS_REPEAT(1'b1)) dut0 (
    .clk(clk), .clrn(clrn), .en(en), .byte_valid(byte_valid), .byte_data(byte_data),
    .ev_valid(ev_valid0), .ev_data(ev_data0), .ev_ready(ev_ready), .ev_count(ev_count0),
    .overflow(overflow0), .clr_ovf(clr_ovf), .err_cnt(err_cnt0), .cur_key(cur_key0));

  ps2_key_event_queue #(.DEPTH(DEPTH), .SUPPRESS_REPEAT(1'b0)) dut1 (
    .clk(clk), .clrn(clrn), .en(en), .byte_valid(byte_valid), .byte_data(byte_data),
    .ev_valid(ev_valid1), .ev_data(ev_data1), .ev_ready(ev_ready), .ev_count(ev_count1),
    .overflow(overflow1), .clr_ovf(clr_ovf), .err_cnt(err_cnt1), .cur_key(cur_key1));

  // ---------------- reference model (index 0: suppression on, 1: off) -------
  bit         m_ext, m_brk;
  int         m_skip, m_err;
  logic [9:0] m_q0[$];
  logic [9:0] m_q1[$];
  bit         m_ovf[2];
  logic [31:0] m_cur[2];
  bit         m_hv[2];
  logic [8:0] m_hk[2];

  function automatic logic [31:0] ref_legacy(input logic [9:0] e);
    if (e == 10'h2E1) return 32'h0000_00E1;
    case (e[9:8])
      2'b00:   return {24'h000000, e[7:0]};
      2'b10:   return {24'h0000E0, e[7:0]};
      2'b01:   return {24'h0000F0, e[7:0]};
      default: return {24'h00E0F0, e[7:0]};
    endcase
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_skip = 0; m_err = 0;
    m_q0.delete(); m_q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_ovf[k] = 0; m_cur[k] = '0; m_hv[k] = 0; m_hk[k] = '0;
    end
  endtask

  task automatic model_edge();
    bit emit, pause, drop, pop, ovf_set;
    logic [9:0] e;
    logic [7:0] b;
    int sz;
    emit = 0; e = '0; b = byte_data;
    if (!en) begin
      m_ext = 0; m_brk = 0; m_skip = 0;
    end else if (byte_valid) begin
      if (m_skip > 0) begin
        m_skip--;
      end else if (b == 8'hE1) begin
        if ((m_ext || m_brk) && m_err < 255) m_err++;
        m_ext = 0; m_brk = 0; emit = 1; e = 10'h2E1; m_skip = 7;
      end else if (b == 8'hE0) begin
        if ((m_ext || m_brk) && m_err < 255) m_err++;
        m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0) begin
        if (m_brk) begin
          if (m_err < 255) m_err++;
          m_ext = 0;
        end
        m_brk = 1;
      end else begin
        emit = 1; e = {m_ext, m_brk, b}; m_ext = 0; m_brk = 0;
      end
    end
    pause = emit && (e == 10'h2E1);
    for (int k = 0; k < 2; k++) begin
      sz   = (k == 0) ? m_q0.size() : m_q1.size();
      pop  = ev_ready && (sz > 0);
      drop = (k == 0) && emit && !e[8] && !pause && m_hv[k] && (m_hk[k] == {e[9], e[7:0]});
      if (pop) begin
        if (k == 0) void'(m_q0.pop_front()); else void'(m_q1.pop_front());
        sz--;
      end
      ovf_set = 0;
      if (emit && !drop) begin
        if (k == 0 && !pause) begin
          if (!e[8]) begin m_hv[k] = 1; m_hk[k] = {e[9], e[7:0]}; end
          else if (m_hk[k] == {e[9], e[7:0]}) m_hv[k] = 0;
        end
        if (sz < DEPTH) begin
          if (k == 0) m_q0.push_back(e); else m_q1.push_back(e);
          m_cur[k] = ref_legacy(e);
        end else begin
          ovf_set = 1;
        end
      end
      m_ovf[k] = ovf_set || (m_ovf[k] && !clr_ovf);
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    logic [9:0] hd;
    for (int k = 0; k < 2; k++) begin
      sz = (k == 0) ? m_q0.size() : m_q1.size();
      hd = (sz == 0) ? 10'h0 : ((k == 0) ? m_q0[0] : m_q1[0]);
      chk($sformatf("dut%0d ev_valid", k), 32'(k ? ev_valid1 : ev_valid0), 32'(sz > 0));
      chk($sformatf("dut%0d ev_data", k),  32'(k ? ev_data1 : ev_data0),   32'(hd));
      chk($sformatf("dut%0d ev_count", k), 32'(k ? ev_count1 : ev_count0), 32'(sz));
      chk($sformatf("dut%0d overflow", k), 32'(k ? overflow1 : overflow0), 32'(m_ovf[k]));
      chk($sformatf("dut%0d err_cnt", k),  32'(k ? err_cnt1 : err_cnt0),   32'(m_err));
      chk($sformatf("dut%0d cur_key", k),  k ? cur_key1 : cur_key0,        m_cur[k]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic rdy);
    byte_valid = v; byte_data = b; ev_ready = rdy;
    cycle();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    byte_valid = 0; ev_ready = 0; clr_ovf = 0; en = 1;
    clrn = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    clrn = 1;
  endtask

  logic [7:0] seq_pause[9];
  logic [7:0] rb;
  int r;
  bit rdy_mode;

  initial begin
    clrn = 0; en = 1; byte_valid = 0; byte_data = '0; ev_ready = 0; clr_ovf = 0;
    model_reset();
    #12;
    check_all();
    clrn = 1;

    // make then break of the same key
    step(1, 8'h1C, 0); step(1, 8'hF0, 0); step(1, 8'h1C, 0); step(0, 8'h00, 0);
    chk("mk/brk cur_key", cur_key0, 32'h0000_F01C);
    chk("mk/brk count", 32'(ev_count0), 32'd2);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1);

    // extended make and extended break
    step(1, 8'hE0, 0); step(1, 8'h75, 0);
    chk("ext make cur_key", cur_key0, 32'h0000_E075);
    step(1, 8'hE0, 0); step(1, 8'hF0, 0); step(1, 8'h75, 0);
    chk("ext brk cur_key", cur_key0, 32'h00E0_F075);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1);

    // typematic repeats
    do_reset();
    step(1, 8'h1C, 0); step(1, 8'h1C, 0); step(1, 8'h1C, 0);
    step(1, 8'hF0, 0); step(1, 8'h1C, 0); step(1, 8'h1C, 0);
    chk("repeat suppressed count", 32'(ev_count0), 32'd3);
    chk("repeat kept count", 32'(ev_count1), 32'd5);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1);

    // Pause sequence followed by a normal make
    do_reset();
    seq_pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h32};
    for (int i = 0; i < 9; i++) step(1, seq_pause[i], 0);
    chk("pause count", 32'(ev_count0), 32'd2);
    chk("pause head", 32'(ev_data0), 32'h2E1);
    chk("pause err_cnt", 32'(err_cnt0), 32'd0);
    step(0, 8'h00, 1);
    chk("pause cur_key", cur_key0, 32'h0000_0032);
    step(0, 8'h00, 1);

    // overflow, clear, and write+pop while full
    do_reset();
    for (int i = 0; i <= DEPTH; i++) step(1, 8'h10 + 8'(i), 0);
    chk("full count", 32'(ev_count0), DEPTH);
    chk("full overflow", 32'(overflow0), 32'd1);
    chk("full head", 32'(ev_data0), 32'h010);
    clr_ovf = 1; step(0, 8'h00, 0); clr_ovf = 0;
    chk("clr overflow", 32'(overflow0), 32'd0);
    step(1, 8'h30, 1);
    chk("wr+pop full count", 32'(ev_count0), DEPTH);
    chk("wr+pop no overflow", 32'(overflow0), 32'd0);
    // overflow and clear in the same cycle: set wins
    clr_ovf = 1; step(1, 8'h31, 0); clr_ovf = 0;
    chk("set beats clear", 32'(overflow0), 32'd1);

    // protocol error, then reset in the middle of a sequence
    do_reset();
    step(1, 8'hF0, 0); step(1, 8'hE0, 0); step(1, 8'h2B, 0);
    chk("err_cnt one", 32'(err_cnt0), 32'd1);
    chk("err event", 32'(ev_data0), 32'h22B);
    do_reset();
    step(1, 8'hE0, 0);
    do_reset();
    step(1, 8'h2B, 0);
    chk("post-reset event", 32'(ev_data0), 32'h02B);

    // en low drops a partial sequence
    do_reset();
    step(1, 8'hE0, 0);
    en = 0; step(1, 8'h44, 0); en = 1;
    step(1, 8'h75, 0);
    chk("en drop event", 32'(ev_data0), 32'h075);

    // err_cnt saturation
    do_reset();
    for (int i = 0; i < 260; i++) step(1, 8'hF0, 0);
    chk("err saturate", 32'(err_cnt0), 32'd255);

    // randomized traffic
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 150 == 0) rdy_mode = ~rdy_mode;
      r = $urandom_range(0, 19);
      case (r)
        0, 1:    rb = 8'hE0;
        2, 3:    rb = 8'hF0;
        4:       rb = 8'hE1;
        5, 6:    rb = 8'h1C;
        7, 8:    rb = 8'h32;
        9, 10:   rb = 8'h75;
        11, 12:  rb = 8'h2B;
        default: rb = 8'($urandom_range(1, 8'hDF));
      endcase
      en      = ($urandom_range(0, 59) != 0);
      clr_ovf = ($urandom_range(0, 39) == 0);
      step($urandom_range(0, 3) != 0, rb,
           rdy_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0));
    end
    clr_ovf = 0; en = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
